regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Write-side front end for the 32 x 32-bit register file. Merges writeback results from the ALU (single-cycle, never stalled) and the load/store unit (variable latency, valid/ready) onto the file's single write port (`select_w`/`data_write`/`write`). LSU results are queued in a small FIFO. A younger ALU write to the same register cancels any queued older LSU write, so the last write in program order always wins.

## Interface
- `DEPTH`, default 4, LSU queue entries; power of two, 2..16.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `alu_valid` input 1: ALU result present this cycle; always accepted.
- `alu_rd` input 5: ALU destination register.
- `alu_data` input 32: ALU result.
- `lsu_valid` input 1: LSU result offered.
- `lsu_ready` output 1: LSU result accepted when `lsu_valid && lsu_ready`.
- `lsu_rd` input 5: LSU destination register.
- `lsu_data` input 32: LSU result.
- `wr_en` output 1: drives register file `write`.
- `wr_sel` output 5: drives register file `select_w`.
- `wr_data` output 32: drives register file `data_write`.
- `busy_mask` output 32: bit r set while a live (uncancelled) queued write targets register r.
- `fifo_full` output 1: queue holds `DEPTH` entries.

## Operation
- Queue entry: {rd, data, live}. Entries are pushed on an LSU handshake, unless bypassed.
- Write port priority per cycle:
  1. `alu_valid`: `wr_en`=1, `wr_sel`=`alu_rd`, `wr_data`=`alu_data`.
  2. Otherwise, if the head entry is live: write the head and pop it.
  3. Otherwise, `wr_en`=0, `wr_sel`=0, `wr_data`=0.
- Dead head entries are popped without a write, even in a cycle where the ALU owns the port. At most one pop per cycle.
- Cancellation: when `alu_valid`, every stored entry with rd == `alu_rd` is cleared to live=0 at the clock edge.
  - An LSU result accepted in the same cycle with `lsu_rd` == `alu_rd` counts as older. It is enqueued dead, or dropped if bypassed.
- `lsu_ready` = !`rst` && count < `DEPTH`. There is no same-cycle pop-through when full.
- Count update: +1 on push, −1 on pop, unchanged when both occur in one cycle. Pointers wrap modulo `DEPTH`.
- `busy_mask` is the OR of the one-hot rd of live stored entries. It is combinational from state and excludes entries accepted this cycle.
- All 32 registers are ordinary. rd = 0 is written like any other register.

## Timing
- ALU path: zero latency. The write is presented in the same cycle as `alu_valid` and lands in the file at that cycle's edge.
- LSU path, without bypass: an entry accepted in cycle N is written earliest in cycle N+1.
  - Each cycle with `alu_valid` delays the queue by one cycle.
  - Queued entries are written in acceptance order.
- Write-port outputs are combinational from `alu_*` and queue head state. They are not registered.
- Reset: while `rst`=1 and in the first cycle after it falls, the queue is empty and `lsu_ready`=0 during `rst`.
  - `wr_en`=0 unless `alu_valid`. `busy_mask`=0. `fifo_full`=0.
- Reset mid-operation discards all queued entries without writing them.

## Configuration
- `REGWB_BYPASS_EN` defined: when the queue is empty, `alu_valid`=0, and an LSU handshake occurs, the LSU result is written in that same cycle (latency 0) and is not enqueued.
  - A bypass that coincides with an ALU write to the same rd cannot occur, because the ALU owns the port in that cycle.
- `REGWB_BYPASS_EN` undefined: every LSU result goes through the queue (minimum latency 1). Port logic has no combinational path from `lsu_*`.

## Test plan
- ALU only: `alu_valid` with rd=5, data=0x1234 for 1 cycle -> `wr_en`=1, `wr_sel`=5, `wr_data`=0x1234 in the same cycle, and the file reads r5=0x1234 afterwards.
- LSU latency: empty queue, no ALU activity, LSU rd=3, data=0xAA -> written the next cycle without the macro, or the same cycle with it. `busy_mask`[3] is 1 for exactly one cycle without the macro and never set with it.
- Fill/back-pressure (DEPTH=4): ALU busy for 6 cycles while the LSU offers 6 results rd=1..6 -> `lsu_ready` drops after 4 accepts and `fifo_full`=1. After the ALU stops, writes occur in order 1,2,3,4, then 5,6 are accepted and written.
- Cancellation: queue rd=7 data=0x11, then ALU rd=7 data=0x22 -> the queued entry is popped without a write, `busy_mask`[7] clears, and r7 ends as 0x22.
- Same-cycle conflict: ALU and LSU handshake in one cycle, both rd=9 (ALU 0x5, LSU 0x6) -> only 0x5 is written, `busy_mask`[9] stays 0, and r9=0x5.
- Reset mid-operation: 3 entries queued, then assert `rst` for 1 cycle -> no queued writes occur, `busy_mask`=0, and `lsu_ready`=1 the cycle after `rst` falls.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - ALU/LSU writeback merge onto the single register file write port.
// Optional REGWB_BYPASS_EN: an LSU result reaching an empty, idle queue is written in its own cycle.
module regfile_wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    output logic        wr_en,
    output logic [4:0]  wr_sel,
    output logic [31:0] wr_data,
    output logic [31:0] busy_mask,
    output logic        fifo_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]       rd_q   [DEPTH];
    logic [4:0]       rd_d   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic q_nonempty;
    logic lsu_fire;
    logic bypass;
    logic push;
    logic pop;

    // Reset masks the stored state so queued entries can never reach the port while rst is high.
    always_comb begin
        q_nonempty = !rst && (count_q != '0);
        lsu_ready  = !rst && (count_q < CW'(DEPTH));
        fifo_full  = !rst && (count_q == CW'(DEPTH));
        lsu_fire   = lsu_valid && lsu_ready;
`ifdef REGWB_BYPASS_EN
        bypass     = lsu_fire && !alu_valid && !q_nonempty;
`else
        bypass     = 1'b0;
`endif
        pop        = q_nonempty && (!alu_valid || !live_q[head_q]);
        push       = lsu_fire && !bypass;

        wr_en   = 1'b0;
        wr_sel  = '0;
        wr_data = '0;
        if (alu_valid) begin
            wr_en   = 1'b1;
            wr_sel  = alu_rd;
            wr_data = alu_data;
        end else if (q_nonempty && live_q[head_q]) begin
            wr_en   = 1'b1;
            wr_sel  = rd_q[head_q];
            wr_data = data_q[head_q];
        end else if (bypass) begin
            wr_en   = 1'b1;
            wr_sel  = lsu_rd;
            wr_data = lsu_data;
        end

        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!rst && live_q[i]) begin
                busy_mask[rd_q[i]] = 1'b1;
            end
        end
    end

    always_comb begin
        rd_d    = rd_q;
        data_d  = data_q;
        live_d  = live_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        // A younger ALU write kills every older queued write to the same register.
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_valid && (rd_q[i] == alu_rd)) begin
                live_d[i] = 1'b0;
            end
        end
        if (pop) begin
            live_d[head_q] = 1'b0;
            head_d         = head_q + AW'(1);
        end
        if (push) begin
            rd_d[tail_q]   = lsu_rd;
            data_d[tail_q] = lsu_data;
            live_d[tail_q] = !(alu_valid && (lsu_rd == alu_rd));
            tail_d         = tail_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            live_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            live_q  <= live_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload needs no reset; live bits alone decide whether a slot matters.
    always_ff @(posedge clk) begin
        rd_q   <= rd_d;
        data_q <= data_d;
    end
endmodule
